// File: rtl/tmr_scrub_ctrl.sv
// Triplicated register bank with 2-of-3 voting, host read/write port,
// fault injection and a background scrubber that repairs single-copy upsets.

module tmr_vote #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] c0,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] out,
    output logic             err1,
    output logic             err2
);
    logic eq01, eq02, eq12;

    always_comb begin
        out  = (c0 & c1) | (c0 & c2) | (c1 & c2);
        eq01 = (c0 == c1);
        eq02 = (c0 == c2);
        eq12 = (c1 == c2);
        err1 = !(eq01 && eq12) && (eq01 || eq02 || eq12);
        err2 = !(eq01 || eq02 || eq12);
    end
endmodule

module tmr_scrub_ctrl #(
    parameter int NUM_REGS     = 8,
    parameter int WIDTH        = 32,
    parameter int SCRUB_PERIOD = 16,
    parameter int CNT_W        = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    input  logic                        rd_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]            rd_data_o,
    output logic                        rd_valid_o,
    output logic                        rd_err1_o,
    output logic                        rd_err2_o,
    input  logic                        scrub_en_i,
    input  logic                        inj_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] inj_addr_i,
    input  logic [1:0]                  inj_copy_i,
    input  logic [WIDTH-1:0]            inj_mask_i,
    output logic [CNT_W-1:0]            corr_cnt_o,
    output logic [CNT_W-1:0]            uncorr_cnt_o,
    output logic                        uncorr_flag_o,
    output logic                        scrub_done_o
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TW-1:0] T_RELOAD = TW'(SCRUB_PERIOD - 1);
    localparam logic [AW-1:0] LAST     = AW'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, READ, CHECK, WB, NEXT} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  mem     [3][NUM_REGS];
    logic [WIDTH-1:0]  mem_nxt [3][NUM_REGS];
    logic [WIDTH-1:0]  lat     [3];
    logic [AW-1:0]     scrub_addr;
    logic [TW-1:0]     timer;
    logic              stale, host_hit, stale_now;
    logic              do_wb, inc_corr, inc_unc;

    logic [WIDTH-1:0]  rd_vote, chk_vote;
    logic              rd_e1, rd_e2, chk_e1, chk_e2;

    tmr_vote #(.WIDTH(WIDTH)) u_rd_vote (
        .c0(mem[0][rd_addr_i]), .c1(mem[1][rd_addr_i]), .c2(mem[2][rd_addr_i]),
        .out(rd_vote), .err1(rd_e1), .err2(rd_e2)
    );

    // Scrub decisions and writeback both use the snapshot taken in READ.
    tmr_vote #(.WIDTH(WIDTH)) u_chk_vote (
        .c0(lat[0]), .c1(lat[1]), .c2(lat[2]),
        .out(chk_vote), .err1(chk_e1), .err2(chk_e2)
    );

    assign host_hit     = wr_en_i && (wr_addr_i == scrub_addr);
    assign stale_now    = stale || host_hit;
    assign scrub_done_o = (state == NEXT) && (scrub_addr == LAST);

    always_comb begin
        state_nxt = state;
        do_wb     = 1'b0;
        inc_corr  = 1'b0;
        inc_unc   = 1'b0;
        case (state)
            IDLE:  if (scrub_en_i && timer == '0) state_nxt = READ;
            READ:  state_nxt = CHECK;
            CHECK: begin
                inc_unc   = chk_e2;
                state_nxt = (chk_e1 && !stale_now) ? WB : NEXT;
            end
            WB: begin
                do_wb     = !stale_now;
                inc_corr  = !stale_now;
                state_nxt = NEXT;
            end
            NEXT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Priority per copy: scrub writeback < host write < injection XOR.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                mem_nxt[c][a] = mem[c][a];
                if (do_wb && scrub_addr == AW'(a))
                    mem_nxt[c][a] = chk_vote;
                if (wr_en_i && wr_addr_i == AW'(a))
                    mem_nxt[c][a] = wr_data_i;
                if (inj_en_i && inj_addr_i == AW'(a) && inj_copy_i == 2'(c))
                    mem_nxt[c][a] = mem_nxt[c][a] ^ inj_mask_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < 3; c++)
                for (int a = 0; a < NUM_REGS; a++)
                    mem[c][a] <= '0;
        end else begin
            for (int c = 0; c < 3; c++)
                for (int a = 0; a < NUM_REGS; a++)
                    mem[c][a] <= mem_nxt[c][a];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            scrub_addr <= '0;
            timer      <= T_RELOAD;
            stale      <= 1'b0;
            for (int c = 0; c < 3; c++) lat[c] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && scrub_en_i)
                timer <= (timer == '0) ? T_RELOAD : timer - 1'b1;
            if (state == READ)
                for (int c = 0; c < 3; c++) lat[c] <= mem[c][scrub_addr];
            // Restart tracking at READ; any host hit until WB marks the word stale.
            stale <= (state == READ) ? host_hit : (stale || host_hit);
            if (state == NEXT)
                scrub_addr <= scrub_addr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            corr_cnt_o    <= '0;
            uncorr_cnt_o  <= '0;
            uncorr_flag_o <= 1'b0;
        end else begin
            if (inc_corr && corr_cnt_o != '1)
                corr_cnt_o <= corr_cnt_o + 1'b1;
            if (inc_unc) begin
                uncorr_flag_o <= 1'b1;
                if (uncorr_cnt_o != '1)
                    uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_err1_o  <= 1'b0;
            rd_err2_o  <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= rd_vote;
                rd_err1_o <= rd_e1;
                rd_err2_o <= rd_e2;
            end
        end
    end
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Scoreboard bench for tmr_scrub_ctrl: a reference copy model predicts reads
// and scrub-pass outcomes; cycle-exact stimulus targets specific FSM windows.

module tb_tmr_scrub_ctrl;
    localparam int NR = 8;
    localparam int W  = 32;
    localparam int CW = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en, scrub_en, inj_en;
    logic [2:0]    wr_addr, rd_addr, inj_addr;
    logic [W-1:0]  wr_data, inj_mask;
    logic [1:0]    inj_copy;
    logic [W-1:0]  rd_data;
    logic          rd_valid, rd_err1, rd_err2, uncorr_flag, scrub_done;
    logic [CW-1:0] corr_cnt, uncorr_cnt;

    tmr_scrub_ctrl #(.NUM_REGS(NR), .WIDTH(W), .SCRUB_PERIOD(16), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_valid_o(rd_valid), .rd_err1_o(rd_err1), .rd_err2_o(rd_err2),
        .scrub_en_i(scrub_en), .inj_en_i(inj_en), .inj_addr_i(inj_addr),
        .inj_copy_i(inj_copy), .inj_mask_i(inj_mask),
        .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt),
        .uncorr_flag_o(uncorr_flag), .scrub_done_o(scrub_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         e1;
        logic         e2;
    } rd_t;

    rd_t          q[$];
    logic [W-1:0] m [3][NR];
    int           mcorr, munc;
    bit           mflag;
    int           n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic rd_t mvote(input int a);
        rd_t r;
        logic [W-1:0] c0, c1, c2;
        c0 = m[0][a]; c1 = m[1][a]; c2 = m[2][a];
        r.d = (c0 & c1) | (c0 & c2) | (c1 & c2);
        r.e2 = (c0 != c1) && (c0 != c2) && (c1 != c2);
        r.e1 = !r.e2 && !((c0 == c1) && (c1 == c2));
        return r;
    endfunction

    function automatic void model_pass();
        for (int a = 0; a < NR; a++) begin
            rd_t r;
            r = mvote(a);
            if (r.e1) begin
                for (int c = 0; c < 3; c++) m[c][a] = r.d;
                if (mcorr < CMAX) mcorr++;
            end
            if (r.e2) begin
                mflag = 1'b1;
                if (munc < CMAX) munc++;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < NR; a++) m[c][a] = '0;
        mcorr = 0; munc = 0; mflag = 1'b0;
    endfunction

    // Read expectations are captured from the model before any same-cycle write.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (q.size() == 0) chk("rd_spurious", 1, 0);
            else begin
                rd_t e;
                e = q.pop_front();
                chk("rd_data", rd_data, e.d);
                chk("rd_err1", rd_err1, e.e1);
                chk("rd_err2", rd_err2, e.e2);
            end
        end
    end

    task automatic cyc_op(input bit we, input int wa, input logic [W-1:0] wd,
                          input bit re, input int ra,
                          input bit ie, input int ia, input int ic, input logic [W-1:0] im);
        wr_en = we; wr_addr = 3'(wa); wr_data = wd;
        rd_en = re; rd_addr = 3'(ra);
        inj_en = ie; inj_addr = 3'(ia); inj_copy = 2'(ic); inj_mask = im;
        if (re) q.push_back(mvote(ra));
        if (we) for (int c = 0; c < 3; c++) m[c][wa] = wd;
        if (ie && ic < 3) m[ic][ia] = m[ic][ia] ^ im;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; inj_en = 1'b0;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);  cyc_op(1, a, d, 0, 0, 0, 0, 0, 0); endtask
    task automatic rd(input int a);                          cyc_op(0, 0, 0, 1, a, 0, 0, 0, 0); endtask
    task automatic inj(input int a, input int c, input logic [W-1:0] k); cyc_op(0, 0, 0, 0, 0, 1, a, c, k); endtask
    task automatic idle(input int n); repeat (n) @(negedge clk); endtask

    task automatic drain(input string tag);
        idle(2);
        chk(tag, q.size(), 0);
        q.delete();
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_corr"}, corr_cnt, mcorr);
        chk({tag, "_unc"}, uncorr_cnt, munc);
        chk({tag, "_flag"}, uncorr_flag, mflag);
    endtask

    task automatic do_reset(input bit se);
        rst = 1'b1; scrub_en = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; inj_en = 1'b0;
        @(negedge clk);
        rst = 1'b0; scrub_en = se;
        model_reset();
        q.delete();
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(negedge clk);
            if (scrub_done) seen = 1'b1;
        end
        scrub_en = 1'b0;
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first, cnt;
        rst = 1'b1; scrub_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0; inj_en = 1'b0;
        wr_addr = '0; rd_addr = '0; inj_addr = '0; inj_copy = '0;
        wr_data = '0; inj_mask = '0;

        // Reset state, plain read, copy index 3 is inert
        do_reset(0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_e1", rd_err1, 0);
        chk("rst_e2", rd_err2, 0);
        chk("rst_done", scrub_done, 0);
        chk_cnts("rst");
        rd(3);
        inj(3, 3, 32'hFFFF_FFFF);
        rd(3);
        drain("t1_drain");

        // Same-cycle write+inject lands on new data; same-cycle read sees old
        cyc_op(1, 1, 32'h55, 0, 0, 1, 1, 2, 32'hF0);
        cyc_op(1, 1, 32'h66, 1, 1, 0, 0, 0, 0);
        rd(1);
        drain("t6_drain");

        // Correctable fault repaired by scrubber
        do_reset(0);
        wr(2, 32'hA5A5_0001);
        inj(2, 1, 32'h0000_00FF);
        rd(2);
        scrub_en = 1'b1;
        wait_done("t2");
        model_pass();
        idle(2);
        chk_cnts("t2");
        rd(2);
        drain("t2_drain");

        // Two copies hit: uncorrectable, left alone
        do_reset(0);
        inj(5, 0, 32'h1);
        inj(5, 1, 32'h2);
        rd(5);
        scrub_en = 1'b1;
        wait_done("t3");
        model_pass();
        idle(2);
        chk_cnts("t3");
        rd(5);
        drain("t3_drain");

        // Host write to addr 4 while its visit is in CHECK cancels writeback
        do_reset(1);
        inj(4, 2, 32'hFF);
        idle(92);
        wr(4, 32'h1234);
        wait_done("t4");
        model_pass();
        idle(2);
        chk_cnts("t4");
        rd(4);
        drain("t4_drain");

        // Fault-free timing: done pulses at cycles 151 and 303
        do_reset(1);
        first = 0; cnt = 0;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            if (scrub_done) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
        scrub_en = 1'b0;
        chk("t5_first_done", first, 151);
        chk("t5_done_cnt", cnt, 2);
        chk_cnts("t5");

        // Correction counter saturation
        do_reset(0);
        for (int a = 0; a < 5; a++) inj(a, a % 3, 32'h1 << a);
        scrub_en = 1'b1;
        wait_done("t7");
        model_pass();
        idle(2);
        chk_cnts("t7");
        for (int a = 0; a < 5; a++) rd(a);
        drain("t7_drain");

        // Reset asserted during WB of addr 0: no writeback, everything zero
        do_reset(1);
        inj(0, 0, 32'h8);
        idle(17);
        rst = 1'b1; scrub_en = 1'b0;
        @(negedge clk);
        model_reset();
        chk("t8_valid", rd_valid, 0);
        chk("t8_data", rd_data, 0);
        chk("t8_done", scrub_done, 0);
        chk_cnts("t8");
        rst = 1'b0;
        idle(2);
        chk_cnts("t8_post");
        rd(0);
        rd(7);
        drain("t8_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
